grain_stream_xor: RTL and testbench

- Downstream consumer of the Grain-128a keystream generator.
- Drives the generator's session control and pulls one keystream bit per advance.
- Packs the bits into bytes, buffers them in a small FIFO, and XORs them with a byte-wide plaintext/ciphertext stream.
- Uses valid/ready handshakes on both the data input and the data output.

---
 rtl/grain_stream_xor.sv | 156 +++++++++++++++
 tb/tb_grain_stream_xor.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grain_stream_xor.sv
// -----------------------------------------------------------------------------
// grain_stream_xor
//
// Consumer of a Grain-128a keystream generator. It runs the generator's session
// control, pulls one keystream bit per advance, packs the bits LSB-first into
// bytes, and buffers the bytes in a small circular FIFO. Each accepted data byte
// is XORed with the oldest buffered keystream byte and presented on a
// registered valid/ready output.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   start       one-cycle pulse; starts (or restarts) a cipher session
//   gen_init    one-cycle request to the generator to reload key/IV
//   gen_ready   generator warmed up; ks_bit is valid
//   ks_bit      current keystream bit from the generator
//   ks_advance  consume ks_bit; generator shifts on this clock edge
//   in_valid    in_data valid
//   in_data     plaintext/ciphertext byte
//   in_ready    block accepts in_data this cycle
//   out_valid   out_data valid
//   out_data    in_data XOR keystream byte
//   out_ready   downstream accepts out_data
//   busy        session active (not idle)
//   byte_count  bytes emitted since the last start, wraps at 2^32
// -----------------------------------------------------------------------------
module grain_stream_xor #(
    parameter int KS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        gen_init,
    input  logic        gen_ready,
    input  logic        ks_bit,
    output logic        ks_advance,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        busy,
    output logic [31:0] byte_count
);

    localparam int AW = (KS_DEPTH > 1) ? $clog2(KS_DEPTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RUN  = 2'd3;

    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(KS_DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [1:0]    state;
    logic [7:0]    fifo_mem [KS_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fifo_cnt;
    logic [2:0]    bit_cnt;
    logic [6:0]    shreg;

    logic fifo_full;
    logic fifo_not_empty;
    logic push;
    logic pop;
    logic out_fire;

    assign fifo_full      = (fifo_cnt == FULL_CNT);
    assign fifo_not_empty = (fifo_cnt != '0);

    // The last bit of a byte is only pulled when there is room to store the
    // completed byte, so a full FIFO stalls the generator at bit 7.
    assign ks_advance = (state == S_RUN) && gen_ready && !(fifo_full && (bit_cnt == 3'd7));
    assign push       = ks_advance && (bit_cnt == 3'd7);

    // Buffered bytes stay usable while the generator is re-warming (WAIT).
    assign in_ready = ((state == S_RUN) || (state == S_WAIT)) && fifo_not_empty &&
                      (!out_valid || out_ready);
    assign pop      = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    assign gen_init = (state == S_LOAD);
    assign busy     = (state != S_IDLE);

    // Keystream byte storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {ks_bit, shreg};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            byte_count <= '0;
        end else if (start) begin
            // New session: anything buffered or in flight belongs to the old key.
            state      <= S_LOAD;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            out_valid  <= 1'b0;
            byte_count <= '0;
        end else begin
            case (state)
                S_LOAD:  state <= S_WAIT;
                S_WAIT:  if (gen_ready) state <= S_RUN;
                S_RUN:   if (!gen_ready) state <= S_WAIT;
                default: state <= state;
            endcase

            // Bits arrive LSB first; bit 7 bypasses the shift register and
            // goes straight into the FIFO together with bits 0..6.
            if (ks_advance) begin
                if (bit_cnt != 3'd7) begin
                    shreg[bit_cnt] <= ks_bit;
                end
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
                2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
                default: fifo_cnt <= fifo_cnt;
            endcase

            if (pop) begin
                out_data   <= in_data ^ fifo_mem[rd_ptr];
                out_valid  <= 1'b1;
                byte_count <= byte_count + 32'd1;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_grain_stream_xor.sv
module tb_grain_stream_xor;

    localparam int KS_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        gen_init;
    logic        gen_ready = 1'b0;
    logic        ks_bit;
    logic        ks_advance;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready = 1'b0;
    logic        busy;
    logic [31:0] byte_count;

    int pass_cnt  = 0;
    int check_cnt = 0;

    // Generator stand-in: a fixed bit sequence per session, restarted by gen_init.
    logic        ks_mem [4096];
    logic [11:0] ks_idx = 12'd0;
    logic [7:0]  in_q  [$];
    logic [7:0]  out_q [$];

    grain_stream_xor #(.KS_DEPTH(KS_DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .gen_init   (gen_init),
        .gen_ready  (gen_ready),
        .ks_bit     (ks_bit),
        .ks_advance (ks_advance),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    assign ks_bit = ks_mem[ks_idx];

    always @(posedge clk) begin
        if (gen_init) ks_idx <= 12'd0;
        else if (ks_advance && ks_idx < 12'd4095) ks_idx <= ks_idx + 12'd1;
        if (in_valid && in_ready) in_q.push_back(in_data);
        if (out_valid && out_ready) out_q.push_back(out_data);
    end

    // Keystream byte n is bits 8n..8n+7 of the session, first bit in bit 0.
    function automatic logic [7:0] ref_byte(int n);
        logic [7:0]  r;
        logic [11:0] a;
        for (int b = 0; b < 8; b++) begin
            a    = 12'(8 * n + b);
            r[b] = ks_mem[a];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_ks_random();
        for (int i = 0; i < 4096; i++) ks_mem[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; gen_ready = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        in_q.delete();
        out_q.delete();
    endtask

    task automatic random_traffic(int n);
        for (int i = 0; i < n; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            tick();
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        fill_ks_random();
        do_reset();
        check_cnt++;
        if ({out_valid, out_data, byte_count, busy, gen_init, ks_advance, in_ready} !== '0)
            $display("FAIL reset_idle: outputs %b_%h_%h_%b%b%b%b, expected all zero",
                     out_valid, out_data, byte_count, busy, gen_init, ks_advance, in_ready);
        else pass_cnt++;

        // Prime a session: FIFO saturates, then one byte is accepted.
        pulse_start();
        gen_ready = 1'b1;
        out_ready = 1'b0;
        repeat (45) tick();
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        tick();
        in_valid = 1'b0;
        check_cnt++;
        if (out_valid !== 1'b1) $display("FAIL midrun_prep: out_valid %b, expected 1", out_valid);
        else pass_cnt++;

        reset = 1'b1;
        #1;
        check_cnt++;
        if ({out_valid, out_data, byte_count, busy, gen_init, ks_advance, in_ready} !== '0)
            $display("FAIL midrun_reset: outputs %b_%h_%h_%b%b%b%b, expected all zero",
                     out_valid, out_data, byte_count, busy, gen_init, ks_advance, in_ready);
        else pass_cnt++;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_cnt++;
            if ({ks_advance, busy} !== 2'b00)
                $display("FAIL post_reset_idle%0d: ks_advance,busy %b%b, expected 00", i, ks_advance, busy);
            else pass_cnt++;
        end
        gen_ready = 1'b0;
    endtask

    task automatic test_session_start();
        do_reset();
        ks_mem[0] = 1'b1;
        for (int i = 1; i < 8; i++) ks_mem[i] = 1'b0;
        for (int i = 8; i < 4096; i++) ks_mem[i] = 1'b1;
        pulse_start();
        check_cnt++;
        if (gen_init !== 1'b1) $display("FAIL gen_init_pulse: gen_init %b, expected 1", gen_init);
        else pass_cnt++;
        tick();
        check_cnt++;
        if ({gen_init, busy, ks_advance} !== 3'b010)
            $display("FAIL gen_init_one_cycle: gen_init,busy,ks_advance %b%b%b, expected 010",
                     gen_init, busy, ks_advance);
        else pass_cnt++;
        repeat (3) tick();
        gen_ready = 1'b1;
        repeat (25) tick();
        out_ready = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b1;
        for (int i = 0; i < 40 && in_q.size() < 2; i++) tick();
        in_valid = 1'b0;
        tick(); tick();
        check_cnt++;
        if (out_q.size() != 2) $display("FAIL first_bytes_count: got %0d, expected 2", out_q.size());
        else pass_cnt++;
        if (out_q.size() >= 2) begin
            check_cnt++;
            if (out_q[0] !== 8'h01) $display("FAIL first_byte: got %h, expected 01", out_q[0]);
            else pass_cnt++;
            check_cnt++;
            if (out_q[1] !== 8'hFF) $display("FAIL second_byte: got %h, expected ff", out_q[1]);
            else pass_cnt++;
        end
        gen_ready = 1'b0;
    endtask

    task automatic test_xor_latency();
        do_reset();
        for (int i = 0; i < 4096; i++) ks_mem[i] = 1'b1;
        pulse_start();
        gen_ready = 1'b1;
        repeat (20) tick();
        out_ready = 1'b1;
        in_data   = 8'h5A;
        in_valid  = 1'b1;
        #1;
        check_cnt++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL xor_pre: in_ready,out_valid %b%b, expected 10", in_ready, out_valid);
        else pass_cnt++;
        tick();
        check_cnt++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5)
            $display("FAIL xor_first: valid %b data %h, expected 1 a5", out_valid, out_data);
        else pass_cnt++;
        in_data = 8'h00;
        tick();
        check_cnt++;
        if (out_valid !== 1'b1 || out_data !== 8'hFF)
            $display("FAIL xor_second: valid %b data %h, expected 1 ff", out_valid, out_data);
        else pass_cnt++;
        in_valid = 1'b0;
        tick();
        check_cnt++;
        if (out_valid !== 1'b0 || byte_count !== 32'd2)
            $display("FAIL xor_done: valid %b count %0d, expected 0 2", out_valid, byte_count);
        else pass_cnt++;
        gen_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        bit         have     = 1'b0;
        int         unstable = 0;
        do_reset();
        fill_ks_random();
        pulse_start();
        gen_ready = 1'b1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'($urandom);
        repeat (60) begin
            tick();
            in_data = 8'($urandom);
            if (out_valid) begin
                if (!have) begin held = out_data; have = 1'b1; end
                else if (out_data !== held) unstable++;
            end
        end
        check_cnt++;
        if (in_q.size() != 1) $display("FAIL bp_accepted: got %0d, expected 1", in_q.size());
        else pass_cnt++;
        check_cnt++;
        if (!have || unstable != 0)
            $display("FAIL bp_hold: seen %b changes %0d, expected 1 0", have, unstable);
        else pass_cnt++;
        check_cnt++;
        if (ks_advance !== 1'b0 || ks_idx !== 12'(8 * (KS_DEPTH + 1) + 7))
            $display("FAIL bp_stall: ks_advance %b bits %0d, expected 0 %0d",
                     ks_advance, ks_idx, 8 * (KS_DEPTH + 1) + 7);
        else pass_cnt++;
        random_traffic(250);
        drain();
        check_cnt++;
        if (out_q.size() != in_q.size() || in_q.size() < 10)
            $display("FAIL bp_count: outputs %0d inputs %0d, expected equal and >=10", out_q.size(), in_q.size());
        else pass_cnt++;
        for (int i = 0; i < in_q.size() && i < out_q.size(); i++) begin
            check_cnt++;
            if (out_q[i] !== (in_q[i] ^ ref_byte(i)))
                $display("FAIL bp_byte%0d: got %h, expected %h", i, out_q[i], in_q[i] ^ ref_byte(i));
            else pass_cnt++;
        end
        gen_ready = 1'b0;
    endtask

    task automatic test_gen_stall();
        logic [11:0] idx0;
        int          stall_adv = 0;
        do_reset();
        fill_ks_random();
        pulse_start();
        gen_ready = 1'b1;
        out_ready = 1'b1;
        repeat (50) tick();
        idx0 = ks_idx;
        gen_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            #1;
            if (ks_advance !== 1'b0) stall_adv++;
            tick();
        end
        in_valid = 1'b0;
        check_cnt++;
        if (stall_adv != 0 || ks_idx !== idx0)
            $display("FAIL stall_no_advance: advances %0d bits %0d, expected 0 %0d", stall_adv, ks_idx, idx0);
        else pass_cnt++;
        check_cnt++;
        if (in_q.size() != KS_DEPTH || busy !== 1'b1)
            $display("FAIL stall_consume: bytes %0d busy %b, expected %0d 1", in_q.size(), busy, KS_DEPTH);
        else pass_cnt++;
        gen_ready = 1'b1;
        #1;
        check_cnt++;
        if (ks_advance !== 1'b0) $display("FAIL stall_wait_state: ks_advance %b, expected 0", ks_advance);
        else pass_cnt++;
        tick();
        check_cnt++;
        if (ks_advance !== 1'b1) $display("FAIL stall_resume: ks_advance %b, expected 1", ks_advance);
        else pass_cnt++;
        random_traffic(200);
        drain();
        check_cnt++;
        if (out_q.size() != in_q.size() || in_q.size() <= KS_DEPTH)
            $display("FAIL stall_count: outputs %0d inputs %0d", out_q.size(), in_q.size());
        else pass_cnt++;
        for (int i = 0; i < in_q.size() && i < out_q.size(); i++) begin
            check_cnt++;
            if (out_q[i] !== (in_q[i] ^ ref_byte(i)))
                $display("FAIL stall_byte%0d: got %h, expected %h", i, out_q[i], in_q[i] ^ ref_byte(i));
            else pass_cnt++;
        end
        gen_ready = 1'b0;
    endtask

    task automatic test_restart();
        do_reset();
        fill_ks_random();
        pulse_start();
        gen_ready = 1'b1;
        out_ready = 1'b0;
        repeat (30) tick();
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        tick();
        in_valid = 1'b0;
        check_cnt++;
        if (out_valid !== 1'b1 || byte_count !== 32'd1)
            $display("FAIL restart_prep: valid %b count %0d, expected 1 1", out_valid, byte_count);
        else pass_cnt++;
        gen_ready = 1'b0;
        fill_ks_random();
        pulse_start();
        check_cnt++;
        if ({out_valid, gen_init, busy} !== 3'b011 || byte_count !== 32'd0)
            $display("FAIL restart_clear: valid,gen_init,busy %b%b%b count %0d, expected 011 0",
                     out_valid, gen_init, busy, byte_count);
        else pass_cnt++;
        tick();
        in_valid = 1'b1;
        #1;
        check_cnt++;
        if ({in_ready, ks_advance, gen_init} !== 3'b000)
            $display("FAIL restart_fifo_empty: in_ready,ks_advance,gen_init %b%b%b, expected 000",
                     in_ready, ks_advance, gen_init);
        else pass_cnt++;
        in_valid  = 1'b0;
        gen_ready = 1'b1;
        random_traffic(150);
        drain();
        check_cnt++;
        if (out_q.size() != in_q.size() || in_q.size() < 5 || byte_count !== 32'(in_q.size()))
            $display("FAIL restart_count: outputs %0d inputs %0d byte_count %0d",
                     out_q.size(), in_q.size(), byte_count);
        else pass_cnt++;
        for (int i = 0; i < in_q.size() && i < out_q.size(); i++) begin
            check_cnt++;
            if (out_q[i] !== (in_q[i] ^ ref_byte(i)))
                $display("FAIL restart_byte%0d: got %h, expected %h", i, out_q[i], in_q[i] ^ ref_byte(i));
            else pass_cnt++;
        end
        gen_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_session_start();
        test_xor_latency();
        test_backpressure();
        test_gen_stall();
        test_restart();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded 500000 time units, expected completion");
        $fatal(1, "timeout");
    end

endmodule
